aes_inv_cipher: RTL and testbench

Iterative AES-128 decryption core. It is the receive-side counterpart of the combinational encryption datapath: it takes a ciphertext block produced by the encryptor under the same 128-bit key and recovers the plaintext. The core computes one round per clock. It expands the key once at load time and derives the round keys backwards on the fly, so only the final round key needs to be stored. It sits between the link/storage interface delivering ciphertext and the consumer of plaintext, using valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 116 +++++++++++
 rtl/aes_inv_round.sv | 38 +++
 rtl/aes_inv_cipher.sv | 108 ++++++++++
 tb/tb_aes_inv_cipher.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and AES-128 arithmetic for the iterative inverse cipher.
// S-boxes are computed from the GF(2^8) inverse plus affine map rather than stored tables.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEY_EXP, READY, ROUND, DONE} state_t;

    // Byte 0 of a block sits in bits [127:120].
    typedef logic [127:0] blk_t;

    localparam logic [3:0] LAST_RC = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic blk_t expand(input blk_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expand step: recover w3..w1 first, since w0 depends on the old w3.
    function automatic blk_t inv_expand(input blk_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] kprev,
    input  logic         last,
    output logic [127:0] nxt
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];
    logic [7:0] mx [16];

    always_comb begin
        // Byte index is 4*column+row; row r is rotated right by r positions.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[4*c+r] = inv_sbox(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = sb[i] ^ kprev[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mx[4*c+0] = mul0e(ak[4*c]) ^ mul0b(ak[4*c+1]) ^ mul0d(ak[4*c+2]) ^ mul09(ak[4*c+3]);
            mx[4*c+1] = mul09(ak[4*c]) ^ mul0e(ak[4*c+1]) ^ mul0b(ak[4*c+2]) ^ mul0d(ak[4*c+3]);
            mx[4*c+2] = mul0d(ak[4*c]) ^ mul09(ak[4*c+1]) ^ mul0e(ak[4*c+2]) ^ mul0b(ak[4*c+3]);
            mx[4*c+3] = mul0b(ak[4*c]) ^ mul0d(ak[4*c+1]) ^ mul09(ak[4*c+2]) ^ mul0e(ak[4*c+3]);
        end
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            nxt[127-8*i -: 8] = last ? ak[i] : mx[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: 10-cycle key load, 10-cycle decrypt, valid/ready on key, input and output.
// Only k10 is kept; earlier round keys are regenerated backwards one per round.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_out,
    output logic         busy
);

    state_t     state;
    blk_t       wk;
    blk_t       klast;
    blk_t       st;
    logic [3:0] rnd;
    logic [3:0] rc_idx;

    blk_t       wk_fwd;
    blk_t       kprev;
    blk_t       round_out;
    logic       last_round;

    assign wk_fwd     = expand(wk, rcon(rc_idx));
    assign kprev      = inv_expand(wk, rcon(rnd));
    assign last_round = (rnd == 4'd1);

    aes_inv_round u_round (
        .st    (st),
        .kprev (kprev),
        .last  (last_round),
        .nxt   (round_out)
    );

    assign key_ready = (state == IDLE) || (state == READY);
    assign in_ready  = (state == READY) && !key_valid;
    assign busy      = (state == KEY_EXP) || (state == ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wk        <= '0;
            klast     <= '0;
            st        <= '0;
            rnd       <= 4'd0;
            rc_idx    <= 4'd0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        wk     <= key;
                        rc_idx <= 4'd1;
                        state  <= KEY_EXP;
                    end
                end
                KEY_EXP: begin
                    wk     <= wk_fwd;
                    rc_idx <= rc_idx + 4'd1;
                    if (rc_idx == LAST_RC) begin
                        klast <= wk_fwd;
                        state <= READY;
                    end
                end
                READY: begin
                    // A new key wins over a pending block.
                    if (key_valid) begin
                        wk     <= key;
                        rc_idx <= 4'd1;
                        state  <= KEY_EXP;
                    end else if (in_valid) begin
                        st    <= data_in ^ klast;
                        wk    <= klast;
                        rnd   <= 4'd10;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    wk  <= kprev;
                    rnd <= rnd - 4'd1;
                    if (last_round) begin
                        data_out  <= round_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors, back-pressure, key/data collision,
// mid-round reset and random round trips through a forward AES reference model.
`timescale 1ns/1ps
module tb_aes_inv_cipher;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] data_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_tab [256];
    logic [7:0] rc_tab [11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    aes_inv_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    // S-box via the multiply-by-3 / divide-by-3 generator walk.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ m_rotl(q, 1) ^ m_rotl(q, 2) ^ m_rotl(q, 3) ^ m_rotl(q, 4);
            sb_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb_tab[0] = 8'h63;
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int i = 2; i < 11; i++) rc_tab[i] = m_xt(rc_tab[i-1]);
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
                      ^ {rc_tab[i/4], 24'h000000};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rd != 10) begin
                    s[4*c+0] = m_xt(t[4*c]) ^ m_xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ m_xt(t[4*c+1]) ^ m_xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_xt(t[4*c+2]) ^ m_xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = m_xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ m_xt(t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_key(input logic [127:0] k, output bit ok);
        int n;
        ok = 1'b0;
        @(negedge clk);
        key_valid = 1'b1;
        key       = k;
        n = 0;
        while (!key_ready && n < 50) begin @(negedge clk); n++; end
        if (!key_ready) begin key_valid = 1'b0; return; end
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        ok = in_ready;
    endtask

    task automatic run_block(input logic [127:0] ct, input bit release_out,
                             output logic [127:0] pt, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        pt  = '0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = ct;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        ok = out_valid;
        pt = data_out;
        if (release_out && ok) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key = '0; data_in = '0;
        #1;
        total++;
        if (key_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || data_out !== 128'h0) begin
            bad++;
            $display("FAIL reset_values got kr=%b ir=%b ov=%b busy=%b dout=%h exp kr=1 ir=0 ov=0 busy=0 dout=0",
                     key_ready, in_ready, out_valid, busy, data_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_key got ir=%b busy=%b exp ir=0 busy=0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fips_c1();
        logic [127:0] pt;
        int lat;
        bit ok;
        send_key(128'h000102030405060708090a0b0c0d0e0f, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL c1_keyload timeout got=0 exp=1"); end
        run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, pt, lat, ok);
        total++;
        if (!ok || pt !== 128'h00112233445566778899aabbccddeeff) begin
            bad++;
            $display("FAIL c1_data got=%h ok=%b exp=00112233445566778899aabbccddeeff", pt, ok);
        end
        total++;
        if (lat !== 10) begin bad++; $display("FAIL c1_latency got=%0d exp=10", lat); end
    endtask

    task automatic test_fips_b();
        logic [127:0] pt;
        int lat;
        bit ok;
        send_key(128'h2b7e151628aed2a6abf7158809cf4f3c, ok);
        total++;
        if (!ok || dut.klast !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++;
            $display("FAIL b_klast got=%h ok=%b exp=d014f9a8c9ee2589e13f0cc8b6630ca6", dut.klast, ok);
        end
        run_block(128'h3925841d02dc09fbdc118597196a0b32, 1'b1, pt, lat, ok);
        total++;
        if (!ok || pt !== 128'h3243f6a8885a308d313198a2e0370734) begin
            bad++;
            $display("FAIL b_data got=%h ok=%b exp=3243f6a8885a308d313198a2e0370734", pt, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k, p1, p2, c1, c2, got;
        int lat;
        bit ok, stable, blocked, ovbad;
        k  = {$urandom, $urandom, $urandom, $urandom};
        p1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        c1 = ref_encrypt(k, p1);
        c2 = ref_encrypt(k, p2);
        send_key(k, ok);
        run_block(c1, 1'b0, got, lat, ok);
        total++;
        if (!ok || got !== p1) begin bad++; $display("FAIL bp_first got=%h exp=%h", got, p1); end
        stable = 1'b1; blocked = 1'b1;
        in_valid = 1'b1;
        data_in  = c2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || data_out !== p1) stable = 1'b0;
            if (in_ready !== 1'b0) blocked = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (!stable) begin bad++; $display("FAIL bp_hold got ov=%b dout=%h exp ov=1 dout=%h", out_valid, data_out, p1); end
        total++;
        if (!blocked) begin bad++; $display("FAIL bp_in_ready got=1 exp=0"); end
        out_ready = 1'b1;
        @(negedge clk);
        ovbad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ovbad = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (ovbad || data_out !== p1) begin
            bad++;
            $display("FAIL bp_release got ov=%b ir=%b dout=%h exp ov=0 ir=1 dout=%h", out_valid, in_ready, data_out, p1);
        end
        run_block(c2, 1'b1, got, lat, ok);
        total++;
        if (!ok || got !== p2) begin bad++; $display("FAIL bp_key_reuse got=%h exp=%h", got, p2); end
    endtask

    task automatic test_collision();
        logic [127:0] kb, pb, cb, got;
        int lat, busy_cnt, n;
        bit ok;
        kb = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        cb = ref_encrypt(kb, pb);
        @(negedge clk);
        key_valid = 1'b1; key = kb;
        in_valid  = 1'b1; data_in = cb;
        #1;
        total++;
        if (in_ready !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL coll_ready got ir=%b kr=%b exp ir=0 kr=1", in_ready, key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
        busy_cnt = 0; n = 0;
        while (busy && n < 30) begin busy_cnt++; @(negedge clk); n++; end
        in_valid = 1'b0;
        total++;
        if (busy_cnt !== 10) begin bad++; $display("FAIL coll_busy got=%0d exp=10", busy_cnt); end
        run_block(cb, 1'b1, got, lat, ok);
        total++;
        if (!ok || got !== pb) begin bad++; $display("FAIL coll_data got=%h exp=%h", got, pb); end
    endtask

    task automatic test_reset_mid_round();
        logic [127:0] k, p, c, got;
        int lat, n;
        bit ok, seen_ov, ir_bad;
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        c = ref_encrypt(k, p);
        send_key(k, ok);
        @(negedge clk);
        in_valid = 1'b1; data_in = c;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (key_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || data_out !== 128'h0) begin
            bad++;
            $display("FAIL rst_async got kr=%b ir=%b ov=%b busy=%b dout=%h exp kr=1 ir=0 ov=0 busy=0 dout=0",
                     key_ready, in_ready, out_valid, busy, data_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; data_in = c;
        seen_ov = 1'b0; ir_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_ov = 1'b1;
            if (in_ready !== 1'b0) ir_bad = 1'b1;
        end
        in_valid = 1'b0;
        total++;
        if (seen_ov) begin bad++; $display("FAIL rst_no_output got ov=1 exp ov=0"); end
        total++;
        if (ir_bad) begin bad++; $display("FAIL rst_need_key got ir=1 exp ir=0"); end
        send_key(k, ok);
        run_block(c, 1'b1, got, lat, ok);
        total++;
        if (!ok || got !== p) begin bad++; $display("FAIL rst_reload got=%h exp=%h", got, p); end
    endtask

    task automatic test_round_trip();
        logic [127:0] k, p, c, got;
        int lat, errs;
        bit ok, ok_k;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = ref_encrypt(k, p);
            send_key(k, ok_k);
            run_block(c, 1'b1, got, lat, ok);
            total++;
            if (!ok_k || !ok || got !== p || lat !== 10) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL rt_%0d got=%h lat=%0d exp=%h lat=10", i, got, lat, p);
            end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_collision();
        test_reset_mid_round();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
